// File: rtl/sr_ff.sv
// Clocked SR flip-flop made of WIDTH independent slices with a registered q/qn pair.
// The s=r=1 case is resolved by BOTH_POLICY and reported on a one-cycle err flag.
module sr_ff #(
  parameter int   WIDTH       = 1,
  parameter logic RST_VAL     = 1'b0,
  parameter int   BOTH_POLICY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] err
);

  typedef enum logic [1:0] {
    POL_HOLD  = 2'd0,
    POL_CLEAR = 2'd1,
    POL_SET   = 2'd2
  } both_pol_e;

  // Out-of-range policy values fall back to hold.
  localparam both_pol_e POLICY = (BOTH_POLICY == 32'sd1) ? POL_CLEAR :
                                 (BOTH_POLICY == 32'sd2) ? POL_SET   : POL_HOLD;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qn_q;
  logic [WIDTH-1:0] err_q, err_d;

  function automatic logic resolve_both(input logic cur);
    logic res;
    case (POLICY)
      POL_HOLD:  res = cur;
      POL_CLEAR: res = 1'b0;
      POL_SET:   res = 1'b1;
      default:   res = cur;
    endcase
    return res;
  endfunction

  // Per-slice next state and conflict flag from the sampled set/reset pair.
  always_comb begin
    q_d   = q_q;
    err_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case ({s[i], r[i]})
        2'b00: q_d[i] = q_q[i];
        2'b01: q_d[i] = 1'b0;
        2'b10: q_d[i] = 1'b1;
        2'b11: begin
          q_d[i]   = resolve_both(q_q[i]);
          err_d[i] = 1'b1;
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  // State registers; qn is registered from ~q_d so it never diverges from ~q.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= {WIDTH{RST_VAL}};
      qn_q  <= {WIDTH{~RST_VAL}};
      err_q <= '0;
    end else begin
      q_q   <= q_d;
      qn_q  <= ~q_d;
      err_q <= err_d;
    end
  end

  assign q   = q_q;
  assign qn  = qn_q;
  assign err = err_q;

endmodule

// File: tb/tb_sr_ff.sv
// Randomised self-checking bench for sr_ff: several parameterisations share one stimulus
// stream and are compared each cycle against a bitwise reference model.
module tb_sr_ff;

  logic       clk;
  logic       rst;
  logic [3:0] s;
  logic [3:0] r;

  logic [3:0] q_a, qn_a, err_a;
  logic [3:0] q_b, qn_b, err_b;
  logic [3:0] q_c, qn_c, err_c;
  logic [3:0] q_d, qn_d, err_d;
  logic       q_e, qn_e, err_e;

  int n_total;
  int n_bad;

  logic [3:0] exp_q [5];
  logic [3:0] exp_err [5];
  int         pol [5];
  logic       rv [5];
  logic [3:0] mask [5];

  sr_ff #(.WIDTH(4), .RST_VAL(1'b0), .BOTH_POLICY(0)) u_a (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q_a), .qn(qn_a), .err(err_a));
  sr_ff #(.WIDTH(4), .RST_VAL(1'b0), .BOTH_POLICY(1)) u_b (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q_b), .qn(qn_b), .err(err_b));
  sr_ff #(.WIDTH(4), .RST_VAL(1'b1), .BOTH_POLICY(2)) u_c (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q_c), .qn(qn_c), .err(err_c));
  sr_ff #(.WIDTH(4), .RST_VAL(1'b0), .BOTH_POLICY(3)) u_d (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q_d), .qn(qn_d), .err(err_d));
  sr_ff u_e (
    .clk(clk), .rst(rst), .s(s[0:0]), .r(r[0:0]), .q(q_e), .qn(qn_e), .err(err_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: hold where neither requested, follow the lone request, policy where both.
  function automatic void model_edge(input logic rst_v, input logic [3:0] sv, input logic [3:0] rv_in);
    logic [3:0] both;
    logic [3:0] hold;
    logic [3:0] both_val;
    for (int k = 0; k < 5; k++) begin
      if (rst_v) begin
        exp_q[k]   = rv[k] ? 4'hF : 4'h0;
        exp_err[k] = 4'h0;
      end else begin
        both     = sv & rv_in;
        hold     = ~sv & ~rv_in;
        both_val = (pol[k] == 2) ? 4'hF : (pol[k] == 1) ? 4'h0 : exp_q[k];
        exp_q[k]   = (exp_q[k] & hold) | (sv & ~rv_in) | (both & both_val);
        exp_err[k] = both;
      end
      exp_q[k]   = exp_q[k] & mask[k];
      exp_err[k] = exp_err[k] & mask[k];
    end
  endfunction

  task automatic check_inst(input int k, input logic [3:0] qv, input logic [3:0] qnv, input logic [3:0] ev);
    chk($sformatf("q[%0d]", k), qv & mask[k], exp_q[k]);
    chk($sformatf("qn[%0d]", k), qnv & mask[k], ~exp_q[k] & mask[k]);
    chk($sformatf("err[%0d]", k), ev & mask[k], exp_err[k]);
  endtask

  task automatic step(input logic rst_v, input logic [3:0] sv, input logic [3:0] rv_in);
    rst = rst_v;
    s   = sv;
    r   = rv_in;
    @(posedge clk);
    model_edge(rst_v, sv, rv_in);
    #1;
    check_inst(0, q_a, qn_a, err_a);
    check_inst(1, q_b, qn_b, err_b);
    check_inst(2, q_c, qn_c, err_c);
    check_inst(3, q_d, qn_d, err_d);
    check_inst(4, {3'b000, q_e}, {3'b000, qn_e}, {3'b000, err_e});
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    pol[0] = 0; rv[0] = 1'b0; mask[0] = 4'hF;
    pol[1] = 1; rv[1] = 1'b0; mask[1] = 4'hF;
    pol[2] = 2; rv[2] = 1'b1; mask[2] = 4'hF;
    pol[3] = 0; rv[3] = 1'b0; mask[3] = 4'hF;
    pol[4] = 0; rv[4] = 1'b0; mask[4] = 4'h1;
    for (int k = 0; k < 5; k++) begin
      exp_q[k]   = 4'h0;
      exp_err[k] = 4'h0;
    end
    rst = 1'b1;
    s   = 4'h0;
    r   = 4'h0;
    @(negedge clk);

    step(1'b1, 4'h0, 4'h0);
    chk("reset_q_const", q_a, 4'h0);
    chk("reset_qn_const", qn_a, 4'hF);
    step(1'b0, 4'h0, 4'h0);
    step(1'b0, 4'h0, 4'h0);
    step(1'b0, 4'hF, 4'h0);
    chk("set_q_const", q_a, 4'hF);
    step(1'b0, 4'h0, 4'hF);
    chk("clr_q_const", q_a, 4'h0);
    step(1'b0, 4'hF, 4'h0);
    step(1'b0, 4'hF, 4'hF);
    chk("both_p0_q", q_a, 4'hF);
    chk("both_p0_err", err_a, 4'hF);
    chk("both_p1_q", q_b, 4'h0);
    chk("both_p2_q", q_c, 4'hF);
    chk("both_p3_hold", q_d, 4'hF);
    step(1'b0, 4'h0, 4'h0);
    chk("err_clears", err_a, 4'h0);
    step(1'b1, 4'hF, 4'h0);
    chk("rst_wins_q", q_a, 4'h0);
    chk("rst_wins_err", err_a, 4'h0);
    step(1'b0, 4'b0101, 4'b0011);
    chk("mixed_q", q_a, 4'b0100);
    chk("mixed_err", err_a, 4'b0001);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
